// File: rtl/mdu_if.sv
// Handshake/bus bundle between the EX-stage sequencer (master) and the
// iterative multiply/divide unit (slave).
interface mdu_if #(
   parameter int XLEN = 32
);
   // start is a one-cycle request sampled only while busy=0 and done=0;
   // done pulses for one cycle with result valid, and result then holds until
   // the next accepted start.
   logic            start;
   logic [2:0]      funct3;
   logic [XLEN-1:0] op_a;
   logic [XLEN-1:0] op_b;
   logic            busy;
   logic            done;
   logic [XLEN-1:0] result;

   modport master (output start, funct3, op_a, op_b, input busy, done, result);
   modport slave  (input start, funct3, op_a, op_b, output busy, done, result);
endinterface

// File: rtl/mdu_iter.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply, restoring divide.
// Optional MDU_FAST_MUL_EN routes all multiplies through a single-cycle multiplier.
module mdu_iter #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 6
) (
   input  logic       clk,
   input  logic       sys_rst,
   mdu_if.slave       bus,
   output logic [1:0] state_dbg
);
   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   state_t            state;
   logic [CNT_W-1:0]  cnt;
   logic [2*XLEN-1:0] acc;
   logic [XLEN-1:0]   mag_b;
   logic [2:0]        op;
   logic              neg_hi;
   logic              neg_lo;
   logic              spec;
   logic [XLEN-1:0]   result_r;

   logic            is_div, a_sgn, b_sgn, a_neg, b_neg, div0, ovf;
   logic [XLEN-1:0] mag_a, mag_b_in, spec_val;

   // Start-time decode: signedness, magnitudes and the no-trap special cases.
   always_comb begin
      is_div = bus.funct3[2];
      a_sgn  = 1'b0;
      b_sgn  = 1'b0;
      case (bus.funct3)
         3'b001, 3'b100, 3'b110: begin
            a_sgn = 1'b1;
            b_sgn = 1'b1;
         end
         3'b010:  a_sgn = 1'b1;
         default: ;
      endcase
      a_neg    = a_sgn & bus.op_a[XLEN-1];
      b_neg    = b_sgn & bus.op_b[XLEN-1];
      mag_a    = a_neg ? -bus.op_a : bus.op_a;
      mag_b_in = b_neg ? -bus.op_b : bus.op_b;
      div0     = is_div && (bus.op_b == '0);
      ovf      = is_div && !bus.funct3[0] && (bus.op_a == {1'b1, {(XLEN-1){1'b0}}})
                 && (bus.op_b == '1);
      if (div0) spec_val = bus.funct3[1] ? bus.op_a : '1;
      else      spec_val = bus.funct3[1] ? '0 : bus.op_a;
   end

`ifdef MDU_FAST_MUL_EN
   logic signed [XLEN:0]     fast_a, fast_b;
   logic signed [2*XLEN+1:0] fast_prod;
   always_comb begin
      fast_a    = $signed({a_sgn & bus.op_a[XLEN-1], bus.op_a});
      fast_b    = $signed({b_sgn & bus.op_b[XLEN-1], bus.op_b});
      fast_prod = fast_a * fast_b;
   end
`endif

   // acc holds {partial product, multiplier} for multiply and
   // {partial remainder, dividend/quotient} for divide.
   logic [XLEN:0]     mul_sum, div_sh;
   logic [XLEN-1:0]   div_diff;
   logic              div_ge;
   logic [2*XLEN-1:0] mul_next, div_next, prod_fix;
   logic [XLEN-1:0]   q_fix, r_fix, fix_val;

   always_comb begin
      mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mag_b} : '0);
      mul_next = {mul_sum, acc[XLEN-1:1]};
      div_sh   = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
      div_ge   = div_sh >= {1'b0, mag_b};
      div_diff = div_sh[XLEN-1:0] - mag_b;
      div_next = div_ge ? {div_diff, acc[XLEN-2:0], 1'b1}
                        : {div_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0};
      prod_fix = neg_hi ? -acc : acc;
      q_fix    = neg_lo ? -acc[XLEN-1:0] : acc[XLEN-1:0];
      r_fix    = neg_hi ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
      if (spec)              fix_val = acc[XLEN-1:0];
      else if (op[2])        fix_val = op[1] ? r_fix : q_fix;
      else if (op == 3'b000) fix_val = prod_fix[XLEN-1:0];
      else                   fix_val = prod_fix[2*XLEN-1:XLEN];
   end

   always_ff @(posedge clk) begin
      if (sys_rst) begin
         state    <= IDLE;
         cnt      <= '0;
         acc      <= '0;
         mag_b    <= '0;
         op       <= '0;
         neg_hi   <= 1'b0;
         neg_lo   <= 1'b0;
         spec     <= 1'b0;
         result_r <= '0;
      end else begin
         case (state)
            IDLE: if (bus.start) begin
               op     <= bus.funct3;
               mag_b  <= mag_b_in;
               cnt    <= '0;
               spec   <= div0 | ovf;
               neg_lo <= a_neg ^ b_neg;
               neg_hi <= is_div ? a_neg : (a_neg ^ b_neg);
               if (div0 | ovf) begin
                  acc   <= {{XLEN{1'b0}}, spec_val};
                  state <= FIX;
`ifdef MDU_FAST_MUL_EN
               end else if (!is_div) begin
                  acc    <= fast_prod[2*XLEN-1:0];
                  neg_hi <= 1'b0;
                  state  <= FIX;
`endif
               end else begin
                  acc   <= {{XLEN{1'b0}}, mag_a};
                  state <= CALC;
               end
            end
            CALC: begin
               acc <= op[2] ? div_next : mul_next;
               if (cnt == CNT_W'(XLEN-1)) state <= FIX;
               else                       cnt   <= cnt + CNT_W'(1);
            end
            FIX: begin
               result_r <= fix_val;
               state    <= DONE;
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.busy   = (state != IDLE);
   assign bus.done   = (state == DONE);
   assign bus.result = result_r;
   assign state_dbg  = state;
endmodule

// File: tb/tb_mdu_iter.sv
// Bench for mdu_iter: directed vector table, multi-cycle handshake/reset
// sequences, and random operations against an arithmetic reference model.
module tb_mdu_iter;
   logic       clk;
   logic       sys_rst;
   logic [1:0] state_dbg;
   int         n_cmp;
   int         n_fail;
   logic [31:0] exp_q[$];

   mdu_if #(.XLEN(32)) bus ();

   mdu_iter dut (
      .clk       (clk),
      .sys_rst   (sys_rst),
      .bus       (bus),
      .state_dbg (state_dbg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      logic        spam;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] ref_mdu(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] b);
      logic signed [63:0] sa, sb;
      logic [63:0] ua, ub, p;
      int ia, ib;
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      ua = {32'b0, a};
      ub = {32'b0, b};
      ia = a;
      ib = b;
      case (f3)
         3'd0: begin p = ua * ub; return p[31:0]; end
         3'd1: begin p = sa * sb; return p[63:32]; end
         3'd2: begin p = 64'(sa) * ub; return p[63:32]; end
         3'd3: begin p = ua * ub; return p[63:32]; end
         3'd4: begin
            if (b == 0) return 32'hFFFFFFFF;
            if (a == 32'h80000000 && b == 32'hFFFFFFFF) return a;
            return 32'(ia / ib);
         end
         3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
         3'd6: begin
            if (b == 0) return a;
            if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
            return 32'(ia % ib);
         end
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   function automatic int exp_latency(input logic [2:0] f3, input logic [31:0] a,
                                      input logic [31:0] b);
      if (f3[2]) begin
         if (b == 0) return 2;
         if (!f3[0] && a == 32'h80000000 && b == 32'hFFFFFFFF) return 2;
         return 34;
      end
`ifdef MDU_FAST_MUL_EN
      return 2;
`else
      return 34;
`endif
   endfunction

   // Issue one op, count cycles to done (start edge = cycle 1), and check
   // latency, result, pulse width and result stability around it.
   task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input logic spam, input string name);
      int lat;
      logic got;
      logic busy_ok;
      logic stable_ok;
      logic [31:0] prev_res;
      logic [31:0] want;
      exp_q.push_back(exp);
      prev_res = bus.result;
      @(negedge clk);
      bus.start  = 1'b1;
      bus.funct3 = f3;
      bus.op_a   = a;
      bus.op_b   = b;
      @(posedge clk);
      #1;
      lat       = 1;
      got       = 1'b0;
      busy_ok   = 1'b1;
      stable_ok = 1'b1;
      while (!got && lat < 100) begin
         bus.start = spam;
         bus.op_a  = $urandom;
         bus.op_b  = $urandom;
         if (bus.done) begin
            got = 1'b1;
         end else begin
            if (!bus.busy) busy_ok = 1'b0;
            if (bus.result !== prev_res) stable_ok = 1'b0;
            @(posedge clk);
            #1;
            lat++;
         end
      end
      want = exp_q.pop_front();
      check({name, " done_seen"}, 32'(got), 32'd1);
      check({name, " busy_while_running"}, 32'(busy_ok), 32'd1);
      check({name, " result_held"}, 32'(stable_ok), 32'd1);
      if (got) begin
         check({name, " latency"}, 32'(lat), 32'(exp_latency(f3, a, b)));
         check({name, " result"}, bus.result, want);
         @(posedge clk);
         #1;
         bus.start = 1'b0;
         check({name, " done_width"}, 32'(bus.done), 32'd0);
         check({name, " idle_after"}, 32'(bus.busy), 32'd0);
         check({name, " result_after"}, bus.result, want);
      end else begin
         bus.start = 1'b0;
      end
   endtask

   vec_t vecs[$];

   initial begin
      n_cmp      = 0;
      n_fail     = 0;
      bus.start  = 1'b0;
      bus.funct3 = 3'd0;
      bus.op_a   = '0;
      bus.op_b   = '0;
      sys_rst    = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      sys_rst = 1'b0;
      check("reset busy", 32'(bus.busy), 32'd0);
      check("reset done", 32'(bus.done), 32'd0);
      check("reset result", bus.result, 32'd0);
      check("reset state", 32'(state_dbg), 32'd0);

      vecs.push_back('{3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 1'b0});
      vecs.push_back('{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0});
      vecs.push_back('{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0});
      vecs.push_back('{3'd0, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0});
      vecs.push_back('{3'd1, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 1'b0});
      vecs.push_back('{3'd4, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 1'b0});
      vecs.push_back('{3'd6, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 1'b0});
      vecs.push_back('{3'd5, 32'd100, 32'd7, 32'd14, 1'b0});
      vecs.push_back('{3'd7, 32'd100, 32'd7, 32'd2, 1'b0});
      vecs.push_back('{3'd5, 32'd100, 32'd0, 32'hFFFFFFFF, 1'b0});
      vecs.push_back('{3'd7, 32'd100, 32'd0, 32'h00000064, 1'b0});
      vecs.push_back('{3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0});
      vecs.push_back('{3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b0});
      vecs.push_back('{3'd6, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 1'b0});
      vecs.push_back('{3'd5, 32'd100, 32'd7, 32'd14, 1'b1});
      vecs.push_back('{3'd4, 32'd100, 32'd0, 32'hFFFFFFFF, 1'b1});
      vecs.push_back('{3'd0, 32'd12345, 32'd678, 32'd8369910, 1'b1});

      for (int i = 0; i < vecs.size(); i++)
         run_op(vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].spam,
                $sformatf("vec%0d", i));

      // Reset in the middle of a divide discards it entirely.
      @(negedge clk);
      bus.start  = 1'b1;
      bus.funct3 = 3'd5;
      bus.op_a   = 32'd100;
      bus.op_b   = 32'd7;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (8) @(posedge clk);
      @(negedge clk);
      sys_rst = 1'b1;
      @(posedge clk);
      #1;
      sys_rst = 1'b0;
      check("midrst busy", 32'(bus.busy), 32'd0);
      check("midrst done", 32'(bus.done), 32'd0);
      check("midrst result", bus.result, 32'd0);
      check("midrst state", 32'(state_dbg), 32'd0);
      run_op(3'd0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0, "after_rst_mul");

      for (int i = 0; i < 40; i++) begin
         logic [2:0]  f3;
         logic [31:0] a, b;
         int sel;
         f3  = 3'($urandom_range(0, 7));
         a   = $urandom;
         b   = $urandom;
         sel = $urandom_range(0, 9);
         if (sel == 0) b = 32'd0;
         else if (sel == 1) begin a = 32'h80000000; b = 32'hFFFFFFFF; end
         else if (sel == 2) b = 32'($urandom_range(1, 15));
         else if (sel == 3) a = 32'($urandom_range(0, 100));
         run_op(f3, a, b, ref_mdu(f3, a, b), 1'($urandom_range(0, 1)),
                $sformatf("rnd%0d_f%0d", i, f3));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
- Iterative RV32M multiply/divide unit in the multi-cycle datapath.
- Sits directly downstream of the register file: op_a and op_b come from the rd1/rd2 operand latches, and result drives the register-file write-data mux.
- Sequences the EX stage through a start/busy/done handshake so the main control FSM stalls until done.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported (RV32).
- CNT_W, 6, iteration counter width; must hold the value XLEN.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- sys_rst  input  1  synchronous reset, active-high.
- start  input  1  one-cycle request; sampled only in IDLE.
- funct3  input  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- op_a  input  XLEN  rs1 value (multiplicand/dividend).
- op_b  input  XLEN  rs2 value (multiplier/divisor).
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle pulse; result valid.
- result  output  XLEN  final value, held stable until next accepted start.

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high on sys_rst.
- Reset (sync, sys_rst=1 at rising edge), including mid-operation:
  - state=IDLE; busy=0, done=0, result=0.
  - Counter, accumulators and latched operands cleared.
  - Operation in progress is discarded.
- States and transitions:
  - IDLE -> CALC on start=1. op_a, op_b and funct3 are latched, operands are converted to magnitudes per signedness, and counter=0.
  - IDLE -> FIX directly on start=1 for a special case (divide-by-zero or signed overflow, see below).
  - CALC: one iteration per cycle; after XLEN iterations (counter==XLEN-1) -> FIX.
  - FIX: apply sign correction, select the high/low half or quotient/remainder, register result -> DONE.
  - DONE: done=1 for exactly one cycle -> IDLE.
- Latency: start at edge N -> done high in cycle N+XLEN+2 (34 cycles for XLEN=32). Special cases complete with done in cycle N+2.
- Multiply:
  - Radix-2 shift-add on the 2*XLEN-bit product of magnitudes.
  - Signedness: MULH both operands signed; MULHSU op_a signed, op_b unsigned; MULHU and MUL unsigned magnitudes.
  - Sign correction: if the product is negative, negate the full 2*XLEN-bit product.
  - Output: MUL returns bits [XLEN-1:0]; MULH, MULHSU and MULHU return bits [2*XLEN-1:XLEN].
- Divide:
  - Restoring, one quotient bit per cycle, MSB first, on magnitudes.
  - DIV/REM signed: quotient negated if signs differ; remainder takes the dividend's sign.
- Special cases (RISC-V spec, no trap):
  - op_b=0: DIV/DIVU -> all ones; REM/REMU -> op_a.
  - DIV with op_a=0x80000000 and op_b=0xFFFFFFFF -> 0x80000000; REM -> 0.
- Handshake:
  - start while busy=1 is ignored; the in-flight operation is unaffected.
  - start in the same cycle as done is ignored; the unit accepts starts again from IDLE on the next cycle.
  - Operand inputs may change after the start cycle without effect.
- result changes only on the FIX->DONE edge or on reset.

Optional Feature:
- Macro: MDU_FAST_MUL_EN.
- Defined:
  - All multiply ops bypass CALC: IDLE -> FIX using a single-cycle XLEN x XLEN signed/unsigned multiplier.
  - Multiply latency: done in cycle N+2.
  - Divide path unchanged.
- Undefined:
  - Iterative multiplier only, XLEN+2 latency.
  - No hardware multiplier is inferred.

Test Plan:
- Reset mid-CALC: start DIVU 100/7, then assert sys_rst at cycle 10 -> next cycle busy=0, done=0, result=0. A new start of MUL 7*0xFFFFFFFD -> done at +34 with result 0xFFFFFFEB.
- MULH 0x80000000*0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD. REM same operands -> 0xFFFFFFFF. DIVU 100/7 -> 14; REMU -> 2. Each done exactly 34 cycles after start, pulse width 1.
- Divide by zero: DIVU 100/0 -> 0xFFFFFFFF. REMU 100/0 -> 0x00000064. Both with done at start+2.
- Overflow: DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0x00000000, done at start+2.
- Handshake: pulse start every cycle during an operation -> only the first accepted, exactly one done pulse. result stays stable while op_a/op_b toggle after start. With MDU_FAST_MUL_EN, MUL 7*0xFFFFFFFD -> 0xFFFFFFEB with done at start+2.
